game_status: RTL and testbench
==============================

# game_status

Game-state tracker sitting directly downstream of the ball-movement stage. It consumes the destroyed-brick bitmap and the bottom-border hit indication, maintains lives and score, and produces the game-over and win indications. `oGAME_OVER` is fed back to the ball-movement stage's `GameOver` input to freeze the ball. Score is also produced in BCD for the seven-segment displays.

## Interface
- `LIVES_INIT`, default 3: lives loaded at reset and on new game; legal range 1..3.
- `NUM_BRICKS`, default 140: width of the brick bitmap; the win threshold.
- `iCLK` in 1: system clock; all logic on rising edge.
- `iRST` in 1: reset; synchronous, active-high.
- `iNEW_GAME` in 1: level; restart the game (driven from SW[16]).
- `iRUN` in 1: level; game running (SW[0] & SW[1]).
- `iFLAG` in NUM_BRICKS: destroyed-brick bitmap (`flag_reg`); bits only rise except on new game.
- `iBOTTOM_HIT` in 1: ball on bottom border; may be high for several cycles per frame.
- `iEND_OF_FRAME` in 1: one-cycle pulse per frame (x==0, y==479).
- `oLIVES` out 2: remaining lives.
- `oSCORE` out 8: count of set bits in `iFLAG`, range 0..NUM_BRICKS.
- `oSCORE_BCD` out 12: `oSCORE` as 3 BCD digits, hundreds in bits [11:8].
- `oLIFE_LOST` out 1: one-cycle pulse when a life is deducted.
- `oGAME_OVER` out 1: high in LOST or WON.
- `oWIN` out 1: high in WON.

## Operation
- **Reset values** (`iRST`, highest priority):
  - state = PLAY, `oLIVES` = LIVES_INIT, hit_seen = 0.
  - `oSCORE` = 0, `oSCORE_BCD` = 0, `oLIFE_LOST` = 0, `oGAME_OVER` = 0, `oWIN` = 0.
  - Scanner in LOAD.
- **Game FSM: PLAY, LOST, WON.**
  - PLAY: hit_seen is set on any cycle with `iBOTTOM_HIT` & `iRUN`.
  - PLAY, on `iEND_OF_FRAME` with hit_seen = 1: `oLIVES` decrements, `oLIFE_LOST` pulses, hit_seen clears. At most one life is lost per frame.
  - PLAY, if that decrement takes `oLIVES` to 0: go to LOST.
  - PLAY, on any cycle with `oSCORE` == NUM_BRICKS: go to WON.
  - LOST and WON hold; hit_seen is ignored and cleared; `oLIVES` is frozen.
  - `iNEW_GAME` (priority below `iRST`, above everything else): state = PLAY, `oLIVES` = LIVES_INIT, hit_seen = 0, `oLIFE_LOST` = 0. Applies in every state and is held as long as the input is high.
  - Win and last-life loss in the same cycle: WON takes priority and `oLIVES` is not decremented.
  - `oGAME_OVER` = (state != PLAY); `oWIN` = (state == WON). Both are registered, derived from the next-state value.
- **Score scanner: LOAD → COUNT → CONVERT → LOAD, free-running regardless of game state.**
  - LOAD (1 cycle): snapshot `iFLAG` into a shadow register; index = 0; accumulator = 0.
  - COUNT (NUM_BRICKS cycles): accumulator += shadow[index]; index++. Leave after index NUM_BRICKS-1.
  - CONVERT (8 cycles): double-dabble on the 8-bit accumulator (add 3 to any digit ≥ 5, then shift left).
  - End of CONVERT: `oSCORE` and `oSCORE_BCD` update together in one cycle, then return to LOAD.
  - Accumulator is 8 bits; NUM_BRICKS ≤ 255 guarantees no overflow.
  - Changes to `iFLAG` after LOAD are ignored until the next LOAD.
  - `iNEW_GAME` does not disturb the scanner; score falls to 0 naturally once upstream clears `flag_reg`.

## Timing
- Scan period: 1 + NUM_BRICKS + 8 = 149 cycles at default.
- Worst-case latency from an `iFLAG` change to the `oSCORE` update: 2×149 − 1 cycles.
- The first `oSCORE` update after reset occurs 149 cycles after `iRST` deasserts.
- Life loss: `oLIVES` and `oLIFE_LOST` change on the edge that samples `iEND_OF_FRAME` = 1. `oLIFE_LOST` is high exactly one cycle.
- Game over: `oGAME_OVER` rises on the same edge that `oLIVES` reaches 0.
- Win: `oGAME_OVER`/`oWIN` rise one cycle after `oSCORE` first equals NUM_BRICKS.
- `iBOTTOM_HIT` coinciding with `iEND_OF_FRAME` counts toward the current frame.
- `iNEW_GAME` takes effect on the next edge; outputs reflect it one cycle later.

## Test plan
- **Reset:** pulse `iRST` mid-COUNT → all outputs at reset values next cycle; first `oSCORE` update exactly 149 cycles later.
- **Score:** `iFLAG` = 37 bits set, held → `oSCORE` = 37, `oSCORE_BCD` = 12'h037 within 298 cycles. All 140 bits set → `oSCORE_BCD` = 12'h140, `oWIN` = 1, `oGAME_OVER` = 1.
- **Life loss:** `iRUN` = 1, `iBOTTOM_HIT` high 7 cycles inside one frame, then `iEND_OF_FRAME` → `oLIVES` 3 → 2, single `oLIFE_LOST` pulse. Same stimulus with `iRUN` = 0 → no change.
- **Game over:** three frames each containing a hit → `oLIVES` = 0, `oGAME_OVER` = 1, `oWIN` = 0. Further hits → no pulse. `iNEW_GAME` for 1 cycle → `oLIVES` = 3, `oGAME_OVER` = 0.
- **Simultaneous win and last life:** `oLIVES` = 1, `oSCORE` reaches 140 on the same edge as a committing `iEND_OF_FRAME` → state WON, `oLIVES` stays 1, no `oLIFE_LOST`.
- **Snapshot:** `iFLAG` changes from 10 set bits to 20 set bits mid-COUNT → that period's `oSCORE` = 10; next period's = 20.

Source files
------------

// File: rtl/game_status.sv
// Breakout game-state tracker: lives, game-over/win FSM and a free-running
// bit-serial brick counter with double-dabble BCD conversion for the displays.
module game_status #(
   parameter int LIVES_INIT = 3,
   parameter int NUM_BRICKS = 140
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic                  iNEW_GAME,
   input  logic                  iRUN,
   input  logic [NUM_BRICKS-1:0] iFLAG,
   input  logic                  iBOTTOM_HIT,
   input  logic                  iEND_OF_FRAME,
   output logic [1:0]            oLIVES,
   output logic [7:0]            oSCORE,
   output logic [11:0]           oSCORE_BCD,
   output logic                  oLIFE_LOST,
   output logic                  oGAME_OVER,
   output logic                  oWIN
);

   localparam int IDX_W = (NUM_BRICKS > 1) ? $clog2(NUM_BRICKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BRICKS - 1);
   localparam logic [7:0]       WIN_SCORE = 8'(NUM_BRICKS);
   localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);

   typedef enum logic [1:0] {PLAY, LOST, WON} gameState_e;
   typedef enum logic [1:0] {LOAD, COUNT, CONVERT} scanState_e;

   gameState_e game_q, game_d;
   logic [1:0] lives_q, lives_d;
   logic       hitSeen_q, hitSeen_d;
   logic       lifeLost_q, lifeLost_d;
   logic       gameOver_q, win_q;
   logic       hitNow, commit;

   scanState_e            scan_q, scan_d;
   logic [NUM_BRICKS-1:0] shadow_q, shadow_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [7:0]            acc_q, acc_d, accSum;
   logic [19:0]           dd_q, dd_d, ddNext;
   logic [2:0]            cnv_q, cnv_d;
   logic [7:0]            score_q, score_d;
   logic [11:0]           bcd_q, bcd_d;

   // One double-dabble iteration on {hundreds, tens, ones, binary}.
   function automatic logic [19:0] ddStep(input logic [19:0] v);
      logic [19:0] t;
      t = v;
      for (int d = 0; d < 3; d++) begin
         if (t[8+4*d +: 4] >= 4'd5) t[8+4*d +: 4] = t[8+4*d +: 4] + 4'd3;
      end
      return {t[18:0], 1'b0};
   endfunction

   assign hitNow = iBOTTOM_HIT & iRUN;
   assign commit = iEND_OF_FRAME & (hitSeen_q | hitNow);
   assign accSum = acc_q + {7'd0, shadow_q[idx_q]};
   assign ddNext = ddStep(dd_q);

   // A win seen in the same cycle as a committing frame end wins outright.
   always_comb begin
      game_d     = game_q;
      lives_d    = lives_q;
      hitSeen_d  = hitSeen_q;
      lifeLost_d = 1'b0;
      if (iNEW_GAME) begin
         game_d    = PLAY;
         lives_d   = LIVES_RST;
         hitSeen_d = 1'b0;
      end else begin
         case (game_q)
            PLAY: begin
               if (score_q == WIN_SCORE) begin
                  game_d    = WON;
                  hitSeen_d = 1'b0;
               end else if (commit) begin
                  lives_d    = lives_q - 2'd1;
                  lifeLost_d = 1'b1;
                  hitSeen_d  = 1'b0;
                  if (lives_q == 2'd1) game_d = LOST;
               end else begin
                  hitSeen_d = hitSeen_q | hitNow;
               end
            end
            default: hitSeen_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         game_q     <= PLAY;
         lives_q    <= LIVES_RST;
         hitSeen_q  <= 1'b0;
         lifeLost_q <= 1'b0;
         gameOver_q <= 1'b0;
         win_q      <= 1'b0;
      end else begin
         game_q     <= game_d;
         lives_q    <= lives_d;
         hitSeen_q  <= hitSeen_d;
         lifeLost_q <= lifeLost_d;
         gameOver_q <= (game_d != PLAY);
         win_q      <= (game_d == WON);
      end
   end

   // Scanner: snapshot, count one bit per cycle, then 8 conversion steps.
   always_comb begin
      scan_d   = scan_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      dd_d     = dd_q;
      cnv_d    = cnv_q;
      score_d  = score_q;
      bcd_d    = bcd_q;
      case (scan_q)
         LOAD: begin
            shadow_d = iFLAG;
            idx_d    = '0;
            acc_d    = 8'd0;
            scan_d   = COUNT;
         end
         COUNT: begin
            acc_d = accSum;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               dd_d   = {12'd0, accSum};
               cnv_d  = 3'd0;
               scan_d = CONVERT;
            end
         end
         CONVERT: begin
            dd_d  = ddNext;
            cnv_d = cnv_q + 3'd1;
            if (cnv_q == 3'd7) begin
               score_d = acc_q;
               bcd_d   = ddNext[19:8];
               scan_d  = LOAD;
            end
         end
         default: scan_d = LOAD;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         scan_q   <= LOAD;
         shadow_q <= '0;
         idx_q    <= '0;
         acc_q    <= 8'd0;
         dd_q     <= 20'd0;
         cnv_q    <= 3'd0;
         score_q  <= 8'd0;
         bcd_q    <= 12'd0;
      end else begin
         scan_q   <= scan_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         dd_q     <= dd_d;
         cnv_q    <= cnv_d;
         score_q  <= score_d;
         bcd_q    <= bcd_d;
      end
   end

   assign oLIVES     = lives_q;
   assign oSCORE     = score_q;
   assign oSCORE_BCD = bcd_q;
   assign oLIFE_LOST = lifeLost_q;
   assign oGAME_OVER = gameOver_q;
   assign oWIN       = win_q;

endmodule

// File: tb/tb_game_status.sv
// Self-checking bench for game_status: directed scenarios plus a randomized
// run, all compared against a frame/period-level model of the game rules.
module tb_game_status;

   localparam int NB     = 140;
   localparam int LI     = 3;
   localparam int PERIOD = 1 + NB + 8;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b1;
   logic          iNEW_GAME = 1'b0;
   logic          iRUN = 1'b0;
   logic [NB-1:0] iFLAG = '0;
   logic          iBOTTOM_HIT = 1'b0;
   logic          iEND_OF_FRAME = 1'b0;
   logic [1:0]    oLIVES;
   logic [7:0]    oSCORE;
   logic [11:0]   oSCORE_BCD;
   logic          oLIFE_LOST;
   logic          oGAME_OVER;
   logic          oWIN;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model state
   int mLives, mScore, mSnap, mPhase;
   bit mLost, mWon, mHit, mPulse;

   always #5 iCLK = ~iCLK;

   game_status #(.LIVES_INIT(LI), .NUM_BRICKS(NB)) dut (
      .iCLK(iCLK), .iRST(iRST), .iNEW_GAME(iNEW_GAME), .iRUN(iRUN),
      .iFLAG(iFLAG), .iBOTTOM_HIT(iBOTTOM_HIT), .iEND_OF_FRAME(iEND_OF_FRAME),
      .oLIVES(oLIVES), .oSCORE(oSCORE), .oSCORE_BCD(oSCORE_BCD),
      .oLIFE_LOST(oLIFE_LOST), .oGAME_OVER(oGAME_OVER), .oWIN(oWIN)
   );

   function automatic logic [11:0] toBcd(input int s);
      return 12'(((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10));
   endfunction

   function automatic logic [NB-1:0] growFlag(input logic [NB-1:0] f, input int n);
      logic [NB-1:0] g;
      int c, p, room;
      g = f;
      room = NB - $countones(f);
      if (n > room) n = room;
      c = 0;
      while (c < n) begin
         p = int'($urandom_range(NB - 1));
         if (!g[p]) begin
            g[p] = 1'b1;
            c++;
         end
      end
      return g;
   endfunction

   // Game rules per frame; score is the popcount seen at the start of each
   // scan period, published at the end of that period.
   task automatic modelEdge();
      bit hitNow;
      if (iRST) begin
         mLives = LI; mLost = 0; mWon = 0; mHit = 0; mPulse = 0;
         mScore = 0; mSnap = 0; mPhase = 0;
      end else begin
         hitNow = iBOTTOM_HIT && iRUN;
         mPulse = 0;
         if (iNEW_GAME) begin
            mLives = LI; mLost = 0; mWon = 0; mHit = 0;
         end else if (mLost || mWon) begin
            mHit = 0;
         end else if (mScore == NB) begin
            mWon = 1; mHit = 0;
         end else if (iEND_OF_FRAME && (mHit || hitNow)) begin
            mLives = mLives - 1; mPulse = 1; mHit = 0;
            if (mLives == 0) mLost = 1;
         end else begin
            mHit = mHit || hitNow;
         end
         if (mPhase == 0) mSnap = $countones(iFLAG);
         if (mPhase == PERIOD - 1) mScore = mSnap;
         mPhase = (mPhase + 1) % PERIOD;
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      modelEdge();
      #1;
   endtask

   task automatic doFrame(input bit run, input int hits);
      iRUN = run;
      repeat (hits) begin
         iBOTTOM_HIT = 1'b1;
         tick();
      end
      iBOTTOM_HIT = 1'b0;
      repeat (3) tick();
      iEND_OF_FRAME = 1'b1;
      tick();
      iEND_OF_FRAME = 1'b0;
   endtask

   task automatic test_reset();
      iRST = 1'b1;
      tick();
      tick();
      iRST = 1'b0;
      iFLAG = growFlag('0, 37);
      repeat (60) tick();
      iRST = 1'b1;
      tick();
      nCompared++;
      if (oLIVES !== 2'd3) begin nMismatched++; $display("[TB] FAIL reset_lives: got %0d, expected 3", oLIVES); end
      nCompared++;
      if (oSCORE !== 8'd0 || oSCORE_BCD !== 12'h000) begin nMismatched++; $display("[TB] FAIL reset_score: got %0d/%h, expected 0/000", oSCORE, oSCORE_BCD); end
      nCompared++;
      if ({oLIFE_LOST, oGAME_OVER, oWIN} !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_flags: got %b, expected 000", {oLIFE_LOST, oGAME_OVER, oWIN}); end
      iRST = 1'b0;
      repeat (PERIOD - 1) tick();
      nCompared++;
      if (oSCORE !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_early_update: got %0d, expected 0", oSCORE); end
      tick();
      nCompared++;
      if (oSCORE !== 8'd37) begin nMismatched++; $display("[TB] FAIL score_37: got %0d, expected 37", oSCORE); end
      nCompared++;
      if (oSCORE_BCD !== 12'h037) begin nMismatched++; $display("[TB] FAIL score_bcd_37: got %h, expected 037", oSCORE_BCD); end
   endtask

   task automatic test_life_loss();
      doFrame(1'b1, 7);
      nCompared++;
      if (oLIVES !== 2'd2 || oLIVES !== 2'(mLives)) begin nMismatched++; $display("[TB] FAIL life_loss_lives: got %0d, expected 2", oLIVES); end
      nCompared++;
      if (oLIFE_LOST !== 1'b1) begin nMismatched++; $display("[TB] FAIL life_lost_pulse: got %b, expected 1", oLIFE_LOST); end
      tick();
      nCompared++;
      if (oLIFE_LOST !== 1'b0) begin nMismatched++; $display("[TB] FAIL life_lost_width: got %b, expected 0", oLIFE_LOST); end
      doFrame(1'b0, 7);
      nCompared++;
      if (oLIVES !== 2'd2 || oLIFE_LOST !== 1'b0) begin nMismatched++; $display("[TB] FAIL no_run_no_loss: got %0d/%b, expected 2/0", oLIVES, oLIFE_LOST); end
   endtask

   task automatic test_game_over();
      iRUN = 1'b1;
      iNEW_GAME = 1'b1;
      tick();
      iNEW_GAME = 1'b0;
      for (int f = 0; f < 3; f++) begin
         doFrame(1'b1, 2);
         nCompared++;
         if (oLIVES !== 2'(2 - f) || oLIFE_LOST !== 1'b1) begin nMismatched++; $display("[TB] FAIL over_frame%0d: got %0d/%b, expected %0d/1", f, oLIVES, oLIFE_LOST, 2 - f); end
      end
      nCompared++;
      if (oGAME_OVER !== 1'b1 || oWIN !== 1'b0) begin nMismatched++; $display("[TB] FAIL game_over_flags: got %b%b, expected 10", oGAME_OVER, oWIN); end
      doFrame(1'b1, 5);
      nCompared++;
      if (oLIFE_LOST !== 1'b0 || oLIVES !== 2'd0 || oGAME_OVER !== 1'b1) begin nMismatched++; $display("[TB] FAIL over_frozen: got %b/%0d/%b, expected 0/0/1", oLIFE_LOST, oLIVES, oGAME_OVER); end
      iNEW_GAME = 1'b1;
      tick();
      iNEW_GAME = 1'b0;
      nCompared++;
      if (oLIVES !== 2'd3 || oGAME_OVER !== 1'b0 || oWIN !== 1'b0) begin nMismatched++; $display("[TB] FAIL new_game: got %0d/%b/%b, expected 3/0/0", oLIVES, oGAME_OVER, oWIN); end
   endtask

   task automatic test_snapshot();
      logic [NB-1:0] f10;
      f10 = growFlag('0, 10);
      iFLAG = f10;
      tick();
      for (int k = 0; k < PERIOD + 2 && mPhase != 1; k++) tick();
      repeat (50) tick();
      iFLAG = growFlag(f10, 10);
      for (int k = 0; k < PERIOD + 2 && mPhase != 0; k++) tick();
      nCompared++;
      if (oSCORE !== 8'd10 || oSCORE_BCD !== 12'h010) begin nMismatched++; $display("[TB] FAIL snapshot_old: got %0d/%h, expected 10/010", oSCORE, oSCORE_BCD); end
      tick();
      for (int k = 0; k < PERIOD + 2 && mPhase != 0; k++) tick();
      nCompared++;
      if (oSCORE !== 8'd20 || oSCORE_BCD !== 12'h020) begin nMismatched++; $display("[TB] FAIL snapshot_new: got %0d/%h, expected 20/020", oSCORE, oSCORE_BCD); end
   endtask

   task automatic test_win_last_life();
      iNEW_GAME = 1'b1;
      tick();
      iNEW_GAME = 1'b0;
      doFrame(1'b1, 3);
      doFrame(1'b1, 3);
      nCompared++;
      if (oLIVES !== 2'd1) begin nMismatched++; $display("[TB] FAIL win_setup_lives: got %0d, expected 1", oLIVES); end
      iFLAG = '1;
      iBOTTOM_HIT = 1'b1;
      tick();
      tick();
      iBOTTOM_HIT = 1'b0;
      for (int k = 0; k < 2 * PERIOD + 2 && mScore != NB; k++) tick();
      nCompared++;
      if (oSCORE !== 8'd140 || oSCORE_BCD !== 12'h140 || oWIN !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_score: got %0d/%h/%b, expected 140/140/0", oSCORE, oSCORE_BCD, oWIN); end
      iEND_OF_FRAME = 1'b1;
      tick();
      iEND_OF_FRAME = 1'b0;
      nCompared++;
      if (oWIN !== 1'b1 || oGAME_OVER !== 1'b1) begin nMismatched++; $display("[TB] FAIL win_flags: got %b%b, expected 11", oWIN, oGAME_OVER); end
      nCompared++;
      if (oLIVES !== 2'd1 || oLIFE_LOST !== 1'b0) begin nMismatched++; $display("[TB] FAIL win_beats_loss: got %0d/%b, expected 1/0", oLIVES, oLIFE_LOST); end
      tick();
      nCompared++;
      if (oLIVES !== 2'd1 || oLIFE_LOST !== 1'b0 || oWIN !== 1'b1) begin nMismatched++; $display("[TB] FAIL win_hold: got %0d/%b/%b, expected 1/0/1", oLIVES, oLIFE_LOST, oWIN); end
   endtask

   task automatic test_random();
      iNEW_GAME = 1'b1;
      iFLAG = '0;
      tick();
      iNEW_GAME = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         iRUN = ($urandom_range(7) != 0);
         iBOTTOM_HIT = ($urandom_range(5) == 0);
         iEND_OF_FRAME = ((c % 37) == 36);
         iNEW_GAME = 1'b0;
         if ($urandom_range(399) == 0) begin
            iNEW_GAME = 1'b1;
            iFLAG = '0;
         end else if ($urandom_range(19) == 0) begin
            iFLAG = growFlag(iFLAG, int'($urandom_range(3, 1)));
         end
         tick();
         nCompared++;
         if (oLIVES !== 2'(mLives)) begin nMismatched++; $display("[TB] FAIL rand_lives c=%0d: got %0d, expected %0d", c, oLIVES, mLives); end
         nCompared++;
         if (oLIFE_LOST !== mPulse) begin nMismatched++; $display("[TB] FAIL rand_pulse c=%0d: got %b, expected %b", c, oLIFE_LOST, mPulse); end
         nCompared++;
         if (oGAME_OVER !== (mLost || mWon) || oWIN !== mWon) begin nMismatched++; $display("[TB] FAIL rand_state c=%0d: got %b%b, expected %b%b", c, oGAME_OVER, oWIN, mLost || mWon, mWon); end
         nCompared++;
         if (oSCORE !== 8'(mScore)) begin nMismatched++; $display("[TB] FAIL rand_score c=%0d: got %0d, expected %0d", c, oSCORE, mScore); end
         nCompared++;
         if (oSCORE_BCD !== toBcd(mScore)) begin nMismatched++; $display("[TB] FAIL rand_bcd c=%0d: got %h, expected %h", c, oSCORE_BCD, toBcd(mScore)); end
      end
      iNEW_GAME = 1'b0;
      iEND_OF_FRAME = 1'b0;
      iBOTTOM_HIT = 1'b0;
   endtask

   initial begin
      $display("[TB] game_status bench start");
      test_reset();
      test_life_loss();
      test_game_over();
      test_snapshot();
      test_win_last_life();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
